// File: rtl/rr_arb_4to1.sv
// Four-requester round-robin arbiter feeding a one-entry registered output stage.
// Per-requester lock keeps multi-beat transfers from being interleaved.
module rr_arb_4to1 #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [3:0]        req_valid_i,
   input  logic [3:0]        req_lock_i,
   input  logic [DATA_W-1:0] req_data0_i,
   input  logic [DATA_W-1:0] req_data1_i,
   input  logic [DATA_W-1:0] req_data2_i,
   input  logic [DATA_W-1:0] req_data3_i,
   output logic [3:0]        req_ready_o,
   output logic [1:0]        mux_sel_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        out_src_o,
   input  logic              out_ready_i,
   output logic              locked_o
);

   typedef enum logic {ST_ARB, ST_LOCK} state_t;

   state_t            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        ptr_q;
   logic              found;
   logic [1:0]        win;
   logic [1:0]        idx;
   logic              space;
   logic              accept;
   logic [DATA_W-1:0] mux_data;

   // Winner search depends only on valid, lock state and ptr, never on data or ready.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      found = 1'b0;
      win   = ptr_q;
      idx   = ptr_q;
      if (state_q == ST_LOCK) begin
         found = req_valid_i[owner_q];
         win   = owner_q;
      end else begin
         for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req_valid_i[idx]) begin
               found = 1'b1;
               win   = idx;
            end
         end
      end
   end

   assign space = !out_valid_o || out_ready_i;

   always_comb begin
      req_ready_o = '0;
      mux_sel_o   = '0;
      if (!rst_i && found) begin
         mux_sel_o = win;
         if (space) req_ready_o[win] = 1'b1;
      end
   end

   assign accept = |req_ready_o;

   always_comb begin
      case (mux_sel_o)
         2'd0:    mux_data = req_data0_i;
         2'd1:    mux_data = req_data1_i;
         2'd2:    mux_data = req_data2_i;
         default: mux_data = req_data3_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         ST_ARB: begin
            if (accept && req_lock_i[mux_sel_o]) begin
               state_d = ST_LOCK;
               owner_d = mux_sel_o;
            end
         end
         default: begin
            // Lock release does not need a beat in the same cycle.
            if (!req_lock_i[owner_q]) state_d = ST_ARB;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst_i) begin
         state_q     <= ST_ARB;
         owner_q     <= '0;
         ptr_q       <= '0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_src_o   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         if (accept) begin
            out_valid_o <= 1'b1;
            out_data_o  <= mux_data;
            out_src_o   <= mux_sel_o;
            ptr_q       <= mux_sel_o + 2'd1;
         end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end

   assign locked_o = (state_q == ST_LOCK);

endmodule

// File: tb/tb_rr_arb_4to1.sv
// Directed bench for rr_arb_4to1: rotation, wrap search, back-pressure, lock, mid-run reset.
module tb_rr_arb_4to1;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  req_valid_i;
   logic [3:0]  req_lock_i;
   logic [31:0] req_data0_i, req_data1_i, req_data2_i, req_data3_i;
   logic [3:0]  req_ready_o;
   logic [1:0]  mux_sel_o;
   logic        out_valid_o;
   logic [31:0] out_data_o;
   logic [1:0]  out_src_o;
   logic        out_ready_i;
   logic        locked_o;

   int n_checks = 0;
   int n_errors = 0;

   rr_arb_4to1 #(.DATA_W(32)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_lock_i  (req_lock_i),
      .req_data0_i (req_data0_i),
      .req_data1_i (req_data1_i),
      .req_data2_i (req_data2_i),
      .req_data3_i (req_data3_i),
      .req_ready_o (req_ready_o),
      .mux_sel_o   (mux_sel_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_src_o   (out_src_o),
      .out_ready_i (out_ready_i),
      .locked_o    (locked_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i       = 1'b1;
      req_valid_i = 4'hf;
      req_lock_i  = 4'h0;
      req_data0_i = 32'hA0;
      req_data1_i = 32'hA1;
      req_data2_i = 32'hA2;
      req_data3_i = 32'hA3;
      out_ready_i = 1'b1;
      step();
      step();
      check("rst_valid",  32'(out_valid_o), 32'd0);
      check("rst_data",   out_data_o,       32'd0);
      check("rst_src",    32'(out_src_o),   32'd0);
      check("rst_locked", 32'(locked_o),    32'd0);
      check("rst_ready",  32'(req_ready_o), 32'd0);
      check("rst_sel",    32'(mux_sel_o),   32'd0);

      // Rotation 0,1,2,3,0,1 with all requesters valid.
      rst_i = 1'b0;
      #1;
      for (int k = 0; k < 6; k++) begin
         check("rot_ready", 32'(req_ready_o), 32'(4'b0001 << (k % 4)));
         check("rot_sel",   32'(mux_sel_o),   32'(k % 4));
         step();
         check("rot_data",  out_data_o,       32'hA0 + 32'(k % 4));
         check("rot_valid", 32'(out_valid_o), 32'd1);
      end

      // ptr=2: accept from 2 moves ptr to 3, then wrap search 3,0,1,2 picks 2 again.
      req_valid_i = 4'b0100;
      #1;
      check("p3_ready_a", 32'(req_ready_o), 32'b0100);
      step();
      req_data2_i = 32'h22;
      #1;
      check("wrap_ready", 32'(req_ready_o), 32'b0100);
      check("wrap_sel",   32'(mux_sel_o),   32'd2);
      step();
      check("wrap_src",   32'(out_src_o),   32'd2);
      check("wrap_data",  out_data_o,       32'h22);

      // Buffer 0x11 from requester 3 (ptr 3 -> 0), then back-pressure.
      req_data3_i = 32'h11;
      req_valid_i = 4'b1000;
      step();
      check("bp_load", out_data_o, 32'h11);
      out_ready_i = 1'b0;
      req_valid_i = 4'b0011;
      req_data0_i = 32'h30;
      req_data1_i = 32'h31;
      #1;
      check("bp_ready", 32'(req_ready_o), 32'd0);
      check("bp_sel",   32'(mux_sel_o),   32'd0);
      step();
      step();
      check("bp_hold_data",  out_data_o,       32'h11);
      check("bp_hold_valid", 32'(out_valid_o), 32'd1);
      out_ready_i = 1'b1;
      #1;
      check("bp_drain_ready", 32'(req_ready_o), 32'b0001);
      step();
      check("bp_swap_data",  out_data_o,       32'h30);
      check("bp_swap_src",   32'(out_src_o),   32'd0);
      check("bp_swap_valid", 32'(out_valid_o), 32'd1);
      req_valid_i = 4'b0000;
      step();
      check("clear_valid", 32'(out_valid_o), 32'd0);
      check("clear_data",  out_data_o,       32'h30);

      // Lock: ptr=1, requester 1 sends three beats while 3 waits.
      req_valid_i = 4'b1010;
      req_lock_i  = 4'b0010;
      req_data1_i = 32'h41;
      #1;
      check("lk1_ready", 32'(req_ready_o), 32'b0010);
      step();
      check("lk1_locked", 32'(locked_o), 32'd1);
      check("lk1_data",   out_data_o,    32'h41);
      req_data1_i = 32'h42;
      #1;
      check("lk2_ready", 32'(req_ready_o), 32'b0010);
      step();
      check("lk2_data", out_data_o, 32'h42);
      req_valid_i = 4'b1000;
      for (int g = 0; g < 2; g++) begin
         #1;
         check("gap_ready",  32'(req_ready_o), 32'd0);
         check("gap_sel",    32'(mux_sel_o),   32'd0);
         check("gap_locked", 32'(locked_o),    32'd1);
         step();
      end
      check("gap_locked_end", 32'(locked_o), 32'd1);
      req_valid_i = 4'b1010;
      req_lock_i  = 4'b0000;
      req_data1_i = 32'h43;
      #1;
      check("lk3_ready", 32'(req_ready_o), 32'b0010);
      step();
      check("lk3_locked", 32'(locked_o), 32'd0);
      check("lk3_data",   out_data_o,    32'h43);
      req_valid_i = 4'b1000;
      #1;
      check("after_lock_ready", 32'(req_ready_o), 32'b1000);

      // Enter LOCK on requester 2 (ptr becomes 3), then reset mid-operation.
      req_valid_i = 4'b0100;
      req_lock_i  = 4'b0100;
      #1;
      check("pre_rst_ready", 32'(req_ready_o), 32'b0100);
      step();
      check("pre_rst_locked", 32'(locked_o),    32'd1);
      check("pre_rst_valid",  32'(out_valid_o), 32'd1);
      rst_i       = 1'b1;
      req_valid_i = 4'hf;
      req_lock_i  = 4'h0;
      #1;
      check("in_rst_ready", 32'(req_ready_o), 32'd0);
      check("in_rst_sel",   32'(mux_sel_o),   32'd0);
      step();
      check("post_rst_valid",  32'(out_valid_o), 32'd0);
      check("post_rst_locked", 32'(locked_o),    32'd0);
      rst_i = 1'b0;
      #1;
      check("post_rst_ready", 32'(req_ready_o), 32'b0001);
      step();
      check("post_rst_src", 32'(out_src_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
